// File: rtl/piecewise_vec_driver.sv
// Streaming driver/checker for the piecewise_fixed evaluator: drives accepted vectors onto
// dut_*, samples dut_y LAT edges later, queues pass/fail records and keeps saturating counters.
module piecewise_vec_driver #(
  parameter int unsigned WID   = 16,
  parameter int unsigned LAT   = 2,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WID-1:0]   in_x,
  input  logic [WID-1:0]   in_a0,
  input  logic [WID-1:0]   in_a1,
  input  logic [WID-1:0]   in_a2,
  input  logic [WID-1:0]   in_a3,
  input  logic [WID-1:0]   in_yexp,
  input  logic             in_last,
  output logic [WID-1:0]   dut_x,
  output logic [WID-1:0]   dut_a0,
  output logic [WID-1:0]   dut_a1,
  output logic [WID-1:0]   dut_a2,
  output logic [WID-1:0]   dut_a3,
  input  logic [WID-1:0]   dut_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WID-1:0]   out_y,
  output logic [WID-1:0]   out_yexp,
  output logic             out_pass,
  output logic             out_last,
  output logic [CNT_W-1:0] num_tests,
  output logic [CNT_W-1:0] num_passed,
  output logic [CNT_W-1:0] num_failed,
  output logic             busy,
  output logic             done
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(DEPTH + 1);
  localparam int unsigned INF_W  = $clog2(LAT + 1);

  generate
    if (LAT < 1 || DEPTH < LAT + 1) begin : g_param_chk
      $error("piecewise_vec_driver: need LAT >= 1 and DEPTH >= LAT+1");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [WID-1:0] y;
    logic [WID-1:0] yexp;
    logic           pass;
    logic           last;
  } rec_t;

  state_t            state, state_n;
  logic              accept, clr, push, pop, ready_n;
  logic [LAT-1:0]    pipe_vld;
  logic [LAT-1:0]    pipe_last;
  logic [WID-1:0]    pipe_yexp [LAT];
  logic [INF_W-1:0]  inflight, inflight_n;
  rec_t              mem [DEPTH];
  rec_t              push_rec, head_n;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [FCNT_W-1:0] fcount, fcount_pop, fcount_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  assign accept = in_valid && in_ready;
  assign clr    = start && (state == IDLE || state == DONE);
  assign push   = pipe_vld[LAT-1];
  assign pop    = out_valid && out_ready;

  // Next state; DRAIN ends once no token is in flight and the FIFO (hence any pop) is empty
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (accept && in_last) state_n = DRAIN;
      DRAIN:   if (inflight == '0 && fcount == '0) state_n = DONE;
      DONE:    if (start) state_n = RUN;
      default: state_n = IDLE;
    endcase
  end

  // Occupancy bookkeeping and the record that becomes the FIFO head after this edge
  always_comb begin
    push_rec.y    = dut_y;
    push_rec.yexp = pipe_yexp[LAT-1];
    push_rec.pass = (dut_y == pipe_yexp[LAT-1]);
    push_rec.last = pipe_last[LAT-1];
    inflight_n    = inflight + INF_W'(accept) - INF_W'(push);
    fcount_pop    = fcount - FCNT_W'(pop);
    fcount_n      = fcount_pop + FCNT_W'(push);
    rd_ptr_n      = pop ? ptr_inc(rd_ptr) : rd_ptr;
    head_n        = (fcount_pop == '0) ? push_rec : mem[rd_ptr_n];
    ready_n       = (state_n == RUN) && ((32'(inflight_n) + 32'(fcount_n)) < DEPTH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_n;
      in_ready <= ready_n;
      busy     <= (state_n == RUN) || (state_n == DRAIN);
      done     <= (state_n == DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dut_x  <= '0;
      dut_a0 <= '0;
      dut_a1 <= '0;
      dut_a2 <= '0;
      dut_a3 <= '0;
    end else if (accept) begin
      dut_x  <= in_x;
      dut_a0 <= in_a0;
      dut_a1 <= in_a1;
      dut_a2 <= in_a2;
      dut_a3 <= in_a3;
    end
  end

  // Token pipeline: valid bits reset, payload does not need to
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_vld <= '0;
      inflight <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) pipe_vld[i] <= pipe_vld[i-1];
      pipe_vld[0] <= accept;
      inflight    <= inflight_n;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = LAT - 1; i > 0; i--) begin
      pipe_yexp[i] <= pipe_yexp[i-1];
      pipe_last[i] <= pipe_last[i-1];
    end
    pipe_yexp[0] <= in_yexp;
    pipe_last[0] <= in_last;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_rec;
  end

  // FWFT result FIFO with the head held in the out_* registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fcount    <= '0;
      out_valid <= 1'b0;
      out_y     <= '0;
      out_yexp  <= '0;
      out_pass  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      rd_ptr    <= rd_ptr_n;
      fcount    <= fcount_n;
      out_valid <= (fcount_n != '0);
      if (fcount_n != '0) begin
        out_y    <= head_n.y;
        out_yexp <= head_n.yexp;
        out_pass <= head_n.pass;
        out_last <= head_n.last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_tests  <= '0;
      num_passed <= '0;
      num_failed <= '0;
    end else if (clr) begin
      num_tests  <= '0;
      num_passed <= '0;
      num_failed <= '0;
    end else if (push) begin
      num_tests <= sat_inc(num_tests);
      if (push_rec.pass) num_passed <= sat_inc(num_passed);
      else               num_failed <= sat_inc(num_failed);
    end
  end

endmodule

// File: tb/tb_piecewise_vec_driver.sv
// Self-checking bench for piecewise_vec_driver with a y = x + a0 evaluator stand-in
// and a queue-based reference model of the expected result stream and counters.
module tb_piecewise_vec_driver;
  localparam int unsigned WID   = 16;
  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CMAX  = 15;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic             in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [WID-1:0]   in_x = '0, in_a0 = '0, in_a1 = '0, in_a2 = '0, in_a3 = '0, in_yexp = '0;
  logic [WID-1:0]   dut_x, dut_a0, dut_a1, dut_a2, dut_a3;
  logic [WID-1:0]   dut_y = '0;
  logic             in_ready, out_valid, out_pass, out_last, busy, done;
  logic [WID-1:0]   out_y, out_yexp;
  logic [CNT_W-1:0] num_tests, num_passed, num_failed;

  typedef struct {
    logic [WID-1:0] y;
    logic [WID-1:0] yexp;
    logic           pass;
    logic           last;
  } exp_t;

  int   total = 0, bad = 0, cyc = 0, accepts = 0, pops = 0;
  int   m_tests = 0, m_pass = 0, m_fail = 0;
  exp_t exp_q[$];
  int   acc_cyc[$];
  exp_t e_mon, n_mon;
  logic [WID-1:0] vx[32], va0[32], va1[32], va2[32], va3[32], vye[32];

  piecewise_vec_driver #(.WID(WID), .LAT(LAT), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_a0(in_a0), .in_a1(in_a1), .in_a2(in_a2), .in_a3(in_a3),
    .in_yexp(in_yexp), .in_last(in_last),
    .dut_x(dut_x), .dut_a0(dut_a0), .dut_a1(dut_a1), .dut_a2(dut_a2), .dut_a3(dut_a3),
    .dut_y(dut_y), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_yexp(out_yexp), .out_pass(out_pass), .out_last(out_last),
    .num_tests(num_tests), .num_passed(num_passed), .num_failed(num_failed),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Evaluator stand-in: one register after the driver's dut_* register gives LAT=2
  always @(posedge clk) dut_y <= dut_x + dut_a0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Scoreboard: record every accept, check every pop against the oldest expected record
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) chk("unexpected_result", 32'(exp_q.size()), 1);
        else begin
          e_mon = exp_q.pop_front();
          chk("out_y", 32'(out_y), 32'(e_mon.y));
          chk("out_yexp", 32'(out_yexp), 32'(e_mon.yexp));
          chk("out_pass", 32'(out_pass), 32'(e_mon.pass));
          chk("out_last", 32'(out_last), 32'(e_mon.last));
        end
      end
      if (in_valid && in_ready) begin
        n_mon.y    = in_x + in_a0;
        n_mon.yexp = in_yexp;
        n_mon.pass = (n_mon.y == in_yexp);
        n_mon.last = in_last;
        exp_q.push_back(n_mon);
        acc_cyc.push_back(cyc);
        accepts++;
        m_tests = sat(m_tests + 1);
        if (n_mon.pass) m_pass = sat(m_pass + 1);
        else            m_fail = sat(m_fail + 1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    m_tests = 0; m_pass = 0; m_fail = 0;
    accepts = 0; pops = 0;
    acc_cyc.delete();
  endtask

  task automatic wait_done();
    int k = 0;
    while (!done && k < 300) begin
      tick(1);
      k++;
    end
    chk("done_reached", 32'(done), 1);
  endtask

  // mode 0: random match/mismatch, 1: alternating match/mismatch, 2: all match
  task automatic fill(input int n, input int mode);
    logic [WID-1:0] s;
    for (int i = 0; i < n; i++) begin
      vx[i] = WID'($urandom); va0[i] = WID'($urandom);
      va1[i] = WID'($urandom); va2[i] = WID'($urandom); va3[i] = WID'($urandom);
      s = vx[i] + va0[i];
      case (mode)
        0:       vye[i] = ($urandom_range(0, 1) == 1) ? s : s ^ WID'($urandom_range(1, 65535));
        1:       vye[i] = (i % 2 == 0) ? s : s + WID'(1);
        default: vye[i] = s;
      endcase
    end
  endtask

  task automatic drive(input int n, input bit last_flag);
    int k;
    for (int i = 0; i < n; i++) begin
      in_x = vx[i]; in_a0 = va0[i]; in_a1 = va1[i]; in_a2 = va2[i]; in_a3 = va3[i];
      in_yexp = vye[i];
      in_last = last_flag && (i == n - 1);
      in_valid = 1'b1;
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!in_ready && k < 500);
      if (!in_ready) begin
        chk("accept_timeout", 32'(in_ready), 1);
        in_valid = 1'b0;
        return;
      end
      tick(1);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 0);
    chk({tag, "_out_valid"}, 32'(out_valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_dut_x"}, 32'(dut_x), 0);
    chk({tag, "_dut_a3"}, 32'(dut_a3), 0);
    chk({tag, "_out_y"}, 32'(out_y), 0);
    chk({tag, "_out_flags"}, 32'({out_pass, out_last}), 0);
    chk({tag, "_counters"}, 32'({num_tests, num_passed, num_failed}), 0);
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_tests"}, 32'(num_tests), 32'(m_tests));
    chk({tag, "_passed"}, 32'(num_passed), 32'(m_pass));
    chk({tag, "_failed"}, 32'(num_failed), 32'(m_fail));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk_reset_vals("reset");
    rst = 1'b0;
    tick(2);
    chk("idle_in_ready", 32'(in_ready), 0);

    // single matching vector, exact latency
    do_start();
    chk("run_busy", 32'(busy), 1);
    chk("run_in_ready", 32'(in_ready), 1);
    vx[0] = 16'd256; va0[0] = 16'd128; va1[0] = '0; va2[0] = '0; va3[0] = '0; vye[0] = 16'd384;
    out_ready = 1'b0;
    drive(1, 1'b1);
    chk("dut_x_loaded", 32'(dut_x), 256);
    chk("dut_a0_loaded", 32'(dut_a0), 128);
    chk("lat_e0", 32'(out_valid), 0);
    tick(1);
    chk("lat_e1", 32'(out_valid), 0);
    tick(1);
    chk("lat_e2", 32'(out_valid), 1);
    chk("t1_pass", 32'(out_pass), 1);
    chk("t1_last", 32'(out_last), 1);
    chk("t1_y", 32'(out_y), 384);
    chk_counters("t1");
    out_ready = 1'b1;
    wait_done();
    chk("t1_pops", 32'(pops), 1);

    // single mismatching vector
    do_start();
    vye[0] = 16'd385;
    drive(1, 1'b1);
    wait_done();
    chk("t2_failed", 32'(num_failed), 1);
    chk_counters("t2");

    // backpressure: credits stop accepts at DEPTH, then resume at 1/cycle
    do_start();
    out_ready = 1'b0;
    fill(10, 0);
    fork
      drive(10, 1'b1);
      begin
        tick(12);
        chk("bp_accepts", 32'(accepts), 4);
        chk("bp_in_ready", 32'(in_ready), 0);
        chk("bp_queued", 32'(num_tests), 4);
        chk("bp_out_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
      end
    join
    wait_done();
    chk("bp_resume_rate", 32'(acc_cyc[9] - acc_cyc[4]), 5);
    chk("bp_pops", 32'(pops), 10);
    chk_counters("bp");

    // back-to-back alternating stream
    do_start();
    fill(8, 1);
    drive(8, 1'b1);
    wait_done();
    chk("b2b_rate", 32'(acc_cyc[7] - acc_cyc[0]), 7);
    chk("b2b_passed", 32'(num_passed), 4);
    chk_counters("b2b");

    // asynchronous reset with two tokens in flight and one result queued
    do_start();
    out_ready = 1'b0;
    fill(3, 2);
    drive(3, 1'b0);
    chk("pre_rst_queued", 32'(num_tests), 1);
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk_reset_vals("async_rst");
    exp_q.delete();
    tick(2);
    rst = 1'b0;
    tick(1);
    do_start();
    out_ready = 1'b1;
    fill(1, 0);
    drive(1, 1'b1);
    wait_done();
    chk("post_rst_tests", 32'(num_tests), 1);
    chk("post_rst_pops", 32'(pops), 1);
    chk("post_rst_queue", 32'(exp_q.size()), 0);

    // counter saturation at 2^CNT_W-1, then clear on start
    do_start();
    fill(17, 2);
    drive(17, 1'b1);
    wait_done();
    chk("sat_tests", 32'(num_tests), 15);
    chk_counters("sat");
    do_start();
    chk_counters("clr");
    chk("clr_busy", 32'(busy), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piecewise_vec_driver.md
# piecewise_vec_driver

Synthesizable streaming driver/checker for the `piecewise_fixed` evaluator. It accepts test vectors (x, a0..a3, expected y) over a valid/ready stream and drives them onto the evaluator inputs. It samples the evaluator output after a fixed latency and compares it to the expected value. It emits one result record per vector and keeps pass/fail counters, so the CSV-driven check can run on hardware (FPGA) without a simulator-side file reader.

## Interface
- `WID`, 16, word width of x, coefficients and y (two's complement).
- `LAT`, 2, evaluator latency in clock edges from `dut_*` update to a valid `dut_y`; ≥1.
- `DEPTH`, 4, result FIFO depth; must be ≥ `LAT`+1 (elaboration error otherwise).
- `CNT_W`, 16, counter width.

- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  pulse; in IDLE or DONE clears counters and enters RUN.
- `in_valid` / `in_ready`  in / out  1  vector stream handshake.
- `in_x`, `in_a0`..`in_a3`, `in_yexp`  in  WID each  vector fields.
- `in_last`  in  1  marks final vector.
- `dut_x`, `dut_a0`..`dut_a3`  out  WID each  registered evaluator inputs.
- `dut_y`  in  WID  evaluator output.
- `out_valid` / `out_ready`  out / in  1  result stream handshake.
- `out_y`, `out_yexp`  out  WID  observed and expected y.
- `out_pass`  out  1  `out_y == out_yexp`.
- `out_last`  out  1  result of the `in_last` vector.
- `num_tests`, `num_passed`, `num_failed`  out  CNT_W  counters.
- `busy`  out  1  state is RUN or DRAIN.
- `done`  out  1  state is DONE.

## Operation
- States:
  - IDLE: `in_ready`=0. `start` → RUN.
  - RUN: accept vectors. Accepting a vector with `in_last`=1 → DRAIN.
  - DRAIN: `in_ready`=0. When the pipeline and FIFO are empty and no pop is pending → DONE.
  - DONE: `done`=1 and held. `start` → RUN with counters cleared.
- `start` in RUN or DRAIN is ignored.
- Accept occurs when `in_valid && in_ready`. On accept, `dut_*` register the vector fields. `dut_*` hold between accepts; no bubble values are driven.
- Each accept pushes a token {`in_yexp`, `in_last`} into a LAT-stage shift pipeline. The pipeline advances every cycle.
- When a token exits the pipeline, `dut_y` is sampled on that edge. {`dut_y`, yexp, pass, last} is pushed into the result FIFO.
- Pass compare is full-width bitwise equality. No tolerance is applied; the saturation vs. truncation choice belongs to the expected data.
- Counters update at FIFO push, not pop:
  - `num_tests` increments on every push.
  - `num_passed` or `num_failed` increments by pass.
  - All counters saturate at 2^CNT_W−1.
- Credit rule: `in_ready` = (state==RUN) && (inflight + fifo_count < DEPTH). Here inflight is the number of valid tokens in the pipeline. This rule guarantees the FIFO never overflows, so the pipeline never stalls.
- Simultaneous FIFO push and pop in the same cycle is legal; the count stays unchanged.
- A pop in a cycle frees one credit for the next cycle's `in_ready`. It does not free a credit combinationally.
- FIFO is first-word-fall-through. `out_*` are valid whenever `out_valid`=1 and stay stable while `out_ready`=0.

## Timing
- Reset values:
  - State IDLE.
  - `in_ready`, `out_valid`, `busy`, `done` = 0.
  - `dut_*`, `out_y`, `out_yexp` = 0.
  - `out_pass`, `out_last` = 0.
  - All counters = 0.
  - Pipeline and FIFO empty.
- Reset asserted mid-run discards all tokens and results immediately (asynchronous).
- A vector accepted at edge E0 appears on `dut_*` after E0. `dut_y` is sampled at edge E0+LAT. `out_valid` rises after E0+LAT if the FIFO was empty. Accept-to-result latency is LAT cycles.
- Sustained throughput is 1 vector/cycle when `out_ready`=1.
- `busy` and `done` are registered decodes of the state and change on the edge after the transition condition.

## Test plan
Bench models the DUT as `dut_y` = `dut_x` + `dut_a0`, delayed LAT=2 registers.

- Reset, `start`, then one vector x=256, a0=128, yexp=384, last=1:
  - `out_valid` rises after accept+2 with `out_pass`=1 and `out_last`=1.
  - Counters read 1/1/0.
  - `done`=1 after the result is popped.
- Vector x=256, a0=128, yexp=385 → `out_pass`=0, `out_y`=384; `num_failed`=1.
- Hold `out_ready`=0 and keep `in_valid`=1 with 10 vectors:
  - Exactly 4 accepts occur, then `in_ready`=0 and the FIFO holds 4.
  - Releasing `out_ready` drains the results in order, and accepts resume at 1/cycle.
- Back-to-back stream of 8 vectors with alternating match/mismatch and `out_ready`=1:
  - One accept per cycle.
  - Results appear in order; `num_passed`=4, `num_failed`=4.
- Assert `rst` while 2 tokens are in flight and 1 result is queued → all outputs return to reset values in the same cycle. After `start`, a fresh vector produces counters 1/x/x with no stale results.
- Preload counters near max (CNT_W=4, 17 matching vectors) → `num_tests` and `num_passed` stick at 15. `start` in DONE clears them to 0.
